lsu_handshake: RTL and testbench
================================

Name: lsu_handshake

Overview:
- Multi-cycle load/store unit sitting directly downstream of the control decoder.
- Consumes the decoder's Load[2:0]/Store[1:0] size codes plus the ALU-computed address and the rs2 store data.
- Drives a req/gnt/rvalid data-memory port, stalls the core while an access is outstanding, and returns aligned, sign/zero-extended load data to the writeback mux.

Parameters:
- AW, 32, byte-address width.
- DW, 32, data width; fixed at 32, with 4 byte lanes.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-low reset
- op_valid  in  1  datapath requests a memory op this cycle
- op_store  in  1  1=store, 0=load
- load_code  in  3  000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu
- store_code  in  2  00 sb, 01 sh, 10 sw
- addr  in  AW  byte address
- wdata  in  DW  store data, LSB-justified
- stall  out  1  hold PC/pipeline
- done  out  1  one-cycle completion pulse
- rdata  out  DW  extended load result, valid while done=1
- misaligned  out  1  fault flag, valid with done
- illegal  out  1  fault flag, valid with done
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  AW  word address, addr[1:0] forced to 00
- mem_be  out  4  byte enables
- mem_wdata  out  DW  lane-shifted store data
- mem_gnt  in  1  memory accepts request
- mem_rvalid  in  1  response / write acknowledge
- mem_rdata  in  DW  raw read word

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE.
  - All outputs 0: mem_req, mem_we, mem_be, mem_addr, mem_wdata, done, rdata, misaligned, illegal.
  - Reset mid-access aborts immediately; a late mem_rvalid arriving in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE with op_valid=1:
  - Latch op_store, code, addr[1:0] and wdata.
  - Illegal code (load_code 101–111, store_code 11) → RESP with illegal=1.
  - Else misaligned (half with addr[0]=1; word with addr[1:0]≠00) → RESP with misaligned=1.
  - Neither fault → REQ. Faults never raise mem_req.
- REQ:
  - mem_req=1; mem_addr, mem_we, mem_be, mem_wdata held stable until mem_gnt=1.
  - When mem_gnt=1: go to WAIT and drop mem_req in the next cycle.
  - mem_rvalid is ignored in REQ.
- WAIT: on mem_rvalid=1, register the extended rdata → RESP.
- RESP: done=1 for exactly one cycle → IDLE. rdata is 0 on stores and faults.
- stall = op_valid & ~done. The datapath holds op_valid and the operands until done.
- IDLE does not accept a new op in the same cycle done is high; back-to-back ops start one cycle after RESP.
- Latency: op_valid at cycle 0, mem_req at cycle 1.
  - Gnt at cycle 1 and rvalid at cycle 2 give done at cycle 3 (minimum).
  - Each wait cycle on gnt or rvalid adds one cycle.
  - Fault path gives done at cycle 1.
- Byte enables:
  - sb: 0001 << addr[1:0].
  - sh: 0011 << addr[1:0], with addr[1] only (0011 or 1100).
  - sw: 1111.
  - Loads: mem_be=1111.
- Store lane shift: mem_wdata = wdata << (8*addr[1:0]); unused lanes replicate the low byte/half.
- Load extract: byte = mem_rdata >> (8*addr[1:0]), taking bits [7:0]; half uses bits [15:0].
  - lb/lh sign-extend to 32 bits; lbu/lhu zero-extend; lw passes through.
- op_valid deasserting mid-access is a protocol violation; the access still completes.

Test Plan:
- lw at 0x100, gnt cycle 1, rvalid cycle 2 with 0xDEADBEEF → mem_addr=0x100, mem_be=1111, mem_we=0; done cycle 3, rdata=0xDEADBEEF, stall high cycles 0–2.
- lb at 0x103, rdata 0x80FF_FF01 → rdata=0xFFFFFF80; lbu same → 0x00000080; lhu at 0x102, rdata 0xABCD1234 → 0x0000ABCD.
- sb at 0x201, wdata 0x000000A5, gnt delayed 3 cycles → mem_be=0010, mem_wdata[15:8]=0xA5, mem_we=1, mem_req and outputs stable 3 cycles; done after rvalid.
- lh at 0x101 → no mem_req, done at cycle 1 with misaligned=1. load_code=110 → done at cycle 1 with illegal=1.
- reset=0 while in WAIT, then rvalid pulses one cycle after reset release → no done, mem_req=0, FSM IDLE; next lw completes normally.
- Two consecutive sw ops (op_valid held) → second mem_req rises exactly 2 cycles after first done pulse; no overlap of requests.

Source files
------------

// File: rtl/lsu_handshake.sv
// rtl/lsu_handshake.sv - multi-cycle load/store unit with req/gnt/rvalid memory port
module lsu_handshake #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          op_valid,
    input  logic          op_store,
    input  logic [2:0]    load_code,
    input  logic [1:0]    store_code,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          stall,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          misaligned,
    output logic          illegal,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t        state;
    logic          store_q;
    logic [2:0]    code_q;
    logic [1:0]    off_q;

    logic          code_bad;
    logic          addr_bad;
    logic [1:0]    size;       // 0 byte, 1 half, 2 word
    logic [3:0]    be_next;
    logic [DW-1:0] wdata_next;
    logic [7:0]    byte_lane;
    logic [15:0]   half_lane;
    logic [DW-1:0] load_ext;

    // The core keeps asking until the completion pulse comes back
    assign stall = op_valid & ~done;

    // Decode the incoming op: legality, alignment, lane enables and replicated store data
    always_comb begin
        code_bad   = 1'b0;
        size       = 2'd0;
        be_next    = 4'b1111;
        wdata_next = '0;
        if (op_store) begin
            code_bad = (store_code == 2'b11);
            size     = store_code;
        end else begin
            case (load_code)
                3'b000, 3'b011: size = 2'd0;
                3'b001, 3'b100: size = 2'd1;
                3'b010:         size = 2'd2;
                default:        code_bad = 1'b1;
            endcase
        end
        addr_bad = ((size == 2'd1) && addr[0]) || ((size == 2'd2) && (addr[1:0] != 2'b00));
        if (op_store) begin
            case (size)
                2'd0: begin
                    be_next    = 4'b0001 << addr[1:0];
                    wdata_next = {4{wdata[7:0]}};
                end
                2'd1: begin
                    be_next    = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_next = {2{wdata[15:0]}};
                end
                default: begin
                    be_next    = 4'b1111;
                    wdata_next = wdata;
                end
            endcase
        end
    end

    // Pick the addressed lane out of the raw read word and extend it
    always_comb begin
        byte_lane = mem_rdata[{off_q, 3'b000} +: 8];
        half_lane = mem_rdata[{off_q[1], 4'b0000} +: 16];
        case (code_q)
            3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
            3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
            3'b010:  load_ext = mem_rdata;
            3'b011:  load_ext = {24'b0, byte_lane};
            3'b100:  load_ext = {16'b0, half_lane};
            default: load_ext = '0;
        endcase
    end

    // Access sequencer: accept, request until granted, wait for response, pulse done
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            store_q    <= 1'b0;
            code_q     <= 3'b000;
            off_q      <= 2'b00;
            done       <= 1'b0;
            rdata      <= '0;
            misaligned <= 1'b0;
            illegal    <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= 4'b0000;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        store_q <= op_store;
                        code_q  <= op_store ? {1'b0, store_code} : load_code;
                        off_q   <= addr[1:0];
                        if (code_bad) begin
                            illegal <= 1'b1;
                            done    <= 1'b1;
                            state   <= RESP;
                        end else if (addr_bad) begin
                            misaligned <= 1'b1;
                            done       <= 1'b1;
                            state      <= RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= op_store;
                            mem_addr  <= {addr[AW-1:2], 2'b00};
                            mem_be    <= be_next;
                            mem_wdata <= wdata_next;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_be    <= 4'b0000;
                        mem_wdata <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        rdata <= store_q ? '0 : load_ext;
                        done  <= 1'b1;
                        state <= RESP;
                    end
                end
                default: begin
                    done       <= 1'b0;
                    rdata      <= '0;
                    misaligned <= 1'b0;
                    illegal    <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_handshake.sv
// tb/tb_lsu_handshake.sv - self-checking bench for lsu_handshake
module tb_lsu_handshake;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_store = 1'b0;
    logic [2:0]  load_code = 3'b000;
    logic [1:0]  store_code = 2'b00;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall, done, misaligned, illegal;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    lsu_handshake #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_store(op_store),
        .load_code(load_code), .store_code(store_code), .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .rdata(rdata), .misaligned(misaligned), .illegal(illegal),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected behaviour of the op currently presented
    logic        exp_active = 1'b0;
    logic        exp_req_ok = 1'b0;
    logic        exp_ill, exp_mis, exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_be;
    bit          mon_en = 1'b0;
    int          last_c0;

    function automatic void model(input logic st, input logic [2:0] lc, input logic [1:0] sc,
                                  input logic [31:0] a, input logic [31:0] wd, input logic [31:0] raw);
        int nb;
        bit sgn;
        logic [31:0] v;
        sgn = 1'b0;
        if (st) begin
            exp_ill = (sc == 2'd3);
            nb = (sc == 2'd0) ? 1 : (sc == 2'd1) ? 2 : 4;
        end else begin
            exp_ill = (lc > 3'd4);
            nb = (lc == 3'd0 || lc == 3'd3) ? 1 : (lc == 3'd1 || lc == 3'd4) ? 2 : 4;
            sgn = (lc < 3'd2);
        end
        exp_mis    = !exp_ill && ((a % nb) != 0);
        exp_req_ok = !exp_ill && !exp_mis;
        exp_addr   = a - (a % 4);
        exp_we     = st;
        exp_be     = st ? 4'(((1 << nb) - 1) << (a % 4)) : 4'hF;
        exp_wdata  = (nb == 1) ? wd[7:0] * 32'h01010101 :
                     (nb == 2) ? wd[15:0] * 32'h00010001 : wd;
        if (st || !exp_req_ok) begin
            exp_rdata = '0;
        end else if (nb == 4) begin
            exp_rdata = raw;
        end else begin
            v = (raw >> (8 * (a % 4))) & ((32'd1 << (8 * nb)) - 1);
            if (sgn && v >= (32'd1 << (8 * nb - 1)))
                v = v - (32'd1 << (8 * nb));
            exp_rdata = v;
        end
    endfunction

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (mon_en) begin
            chk("stall", 32'(stall), 32'(op_valid & ~done));
            chk("req_allowed", 32'(mem_req & ~exp_req_ok), 32'd0);
            chk("done_allowed", 32'(done & ~exp_active), 32'd0);
            if (mem_req && exp_req_ok) begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_be", 32'(mem_be), 32'(exp_be));
                chk("mem_we", 32'(mem_we), 32'(exp_we));
                if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
            end
            if (done && exp_active) begin
                chk("rdata", rdata, exp_rdata);
                chk("misaligned", 32'(misaligned), 32'(exp_mis));
                chk("illegal", 32'(illegal), 32'(exp_ill));
            end
        end
    end

    // Called at posedge+1; drives one op and plays the memory side
    task automatic do_op(input logic st, input logic [2:0] lc, input logic [1:0] sc,
                         input logic [31:0] a, input logic [31:0] wd, input int gd, input int rd,
                         input logic [31:0] raw, input bit keep,
                         output int done_off, output int req_off, output logic [31:0] got);
        bit granted;
        int gcyc;
        bit legal;
        model(st, lc, sc, a, wd, raw);
        legal = exp_req_ok;
        exp_active = 1'b1;
        op_valid = 1'b1; op_store = st; load_code = lc; store_code = sc; addr = a; wdata = wd;
        last_c0 = cyc;
        done_off = -1; req_off = -1; got = '0; granted = 1'b0; gcyc = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (mem_req && req_off < 0) req_off = cyc - last_c0;
            mem_gnt = mem_req && ((cyc - last_c0 - req_off) == gd);
            if (mem_gnt) begin
                granted = 1'b1;
                gcyc = cyc;
            end
            mem_rvalid = granted && !mem_gnt && ((cyc - gcyc - 1) == rd);
            mem_rdata  = mem_rvalid ? raw : 32'h5A5A_5A5A;
            if (done) begin
                done_off = cyc - last_c0;
                got = rdata;
                break;
            end
        end
        chk("latency", 32'(done_off), legal ? 32'(3 + gd + rd) : 32'd1);
        if (!legal) chk("fault_no_req", 32'(req_off), 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        exp_active = 1'b0;
        exp_req_ok = 1'b0;
        if (!keep) op_valid = 1'b0;
    endtask

    int d_off, r_off, c0_a, d_a;
    logic [31:0] got;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_be", 32'(mem_be), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_misaligned", 32'(misaligned), 0);
        chk("rst_illegal", 32'(illegal), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // lw, minimum latency
        do_op(1'b0, 3'b010, 2'b00, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, d_off, r_off, got);
        chk("lw_rdata_lit", got, 32'hDEADBEEF);
        chk("lw_req_cycle", 32'(r_off), 32'd1);
        chk("lw_done_lit", 32'(d_off), 32'd3);
        // byte/half extraction
        do_op(1'b0, 3'b000, 2'b00, 32'h103, 32'h0, 1, 0, 32'h80FF_FF01, 1'b0, d_off, r_off, got);
        chk("lb_rdata_lit", got, 32'hFFFFFF80);
        do_op(1'b0, 3'b011, 2'b00, 32'h103, 32'h0, 0, 2, 32'h80FF_FF01, 1'b0, d_off, r_off, got);
        chk("lbu_rdata_lit", got, 32'h00000080);
        do_op(1'b0, 3'b100, 2'b00, 32'h102, 32'h0, 0, 0, 32'hABCD_1234, 1'b0, d_off, r_off, got);
        chk("lhu_rdata_lit", got, 32'h0000ABCD);
        do_op(1'b0, 3'b001, 2'b00, 32'h102, 32'h0, 0, 0, 32'h8001_7FFF, 1'b0, d_off, r_off, got);
        chk("lh_rdata_lit", got, 32'hFFFF8001);
        do_op(1'b0, 3'b000, 2'b00, 32'h101, 32'h0, 0, 0, 32'h1234_7F00, 1'b0, d_off, r_off, got);
        chk("lb_pos_lit", got, 32'h0000007F);
        // stores
        do_op(1'b1, 3'b000, 2'b00, 32'h201, 32'h0000_00A5, 3, 1, 32'h0, 1'b0, d_off, r_off, got);
        chk("sb_be_model", 32'(exp_be), 32'h2);
        chk("sb_wdata_model", 32'(exp_wdata[15:8]), 32'hA5);
        chk("sb_rdata_zero", got, 32'h0);
        chk("sb_done_lit", 32'(d_off), 32'd7);
        do_op(1'b1, 3'b000, 2'b01, 32'h202, 32'h1234_BEEF, 0, 0, 32'h0, 1'b0, d_off, r_off, got);
        chk("sh_be_model", 32'(exp_be), 32'hC);
        chk("sh_wdata_model", exp_wdata, 32'hBEEF_BEEF);
        // faults
        do_op(1'b0, 3'b001, 2'b00, 32'h101, 32'h0, 0, 0, 32'h0, 1'b0, d_off, r_off, got);
        chk("lh_mis_done_lit", 32'(d_off), 32'd1);
        do_op(1'b0, 3'b110, 2'b00, 32'h100, 32'h0, 0, 0, 32'h0, 1'b0, d_off, r_off, got);
        chk("ill_load_done_lit", 32'(d_off), 32'd1);
        do_op(1'b1, 3'b000, 2'b11, 32'h100, 32'h0, 0, 0, 32'h0, 1'b0, d_off, r_off, got);
        do_op(1'b1, 3'b000, 2'b10, 32'h102, 32'h0, 0, 0, 32'h0, 1'b0, d_off, r_off, got);

        // reset while waiting for the response
        model(1'b0, 3'b010, 2'b00, 32'h300, 32'h0, 32'h1111_1111);
        exp_active = 1'b1;
        op_valid = 1'b1; op_store = 1'b0; load_code = 3'b010; addr = 32'h300;
        @(negedge clk);
        @(negedge clk);
        chk("rst_test_req", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        reset = 1'b0;
        op_valid = 1'b0;
        exp_active = 1'b0;
        exp_req_ok = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_req", 32'(mem_req), 0);
        chk("abort_done", 32'(done), 0);
        @(posedge clk); #1;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h1111_1111;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("late_rvalid_done", 32'(done), 0);
            chk("late_rvalid_req", 32'(mem_req), 0);
        end
        @(posedge clk); #1;
        do_op(1'b0, 3'b010, 2'b00, 32'h304, 32'h0, 0, 0, 32'hCAFE_F00D, 1'b0, d_off, r_off, got);
        chk("post_rst_lw_lit", got, 32'hCAFE_F00D);

        // back-to-back stores with op_valid held
        do_op(1'b1, 3'b000, 2'b10, 32'h400, 32'h1111_2222, 0, 1, 32'h0, 1'b1, d_off, r_off, got);
        d_a = last_c0 + d_off;
        do_op(1'b1, 3'b000, 2'b10, 32'h404, 32'h3333_4444, 1, 0, 32'h0, 1'b0, d_off, r_off, got);
        c0_a = last_c0 + r_off;
        chk("b2b_req_gap", 32'(c0_a - d_a), 32'd2);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
